bcd_adder: RTL and testbench

Registered packed-BCD adder. Adds two DIGITS-wide BCD operands plus a carry-in and produces a BCD sum and a decimal carry-out one clock after a valid input. It is used wherever decimal counters or accumulators need a decimal carry chain. Default configuration is a single digit (4-bit operands).

---
 rtl/bcd_pkg.sv | 9 +
 rtl/bcd_adder_if.sv | 25 ++
 rtl/bcd_digit_add.sv | 28 ++
 rtl/bcd_adder.sv | 57 +++++
 tb/tb_bcd_adder.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the packed-BCD adder.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_ADJ = 4'd6;

endpackage

// File: rtl/bcd_adder_if.sv
// Operand/result bundle for bcd_adder; master drives operands, slave returns results.
interface bcd_adder_if #(
    parameter int unsigned DIGITS = 1
);

    logic                  in_valid;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic [4*DIGITS-1:0]   sum;
    logic                  carry;
    logic                  out_valid;
    logic                  err;

    modport master (
        output in_valid, a, b, cin,
        input  sum, carry, out_valid, err
    );

    modport slave (
        input  in_valid, a, b, cin,
        output sum, carry, out_valid, err
    );

endinterface

// File: rtl/bcd_digit_add.sv
// One combinational BCD digit slice: binary add, then +6 correction above 9.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       ci,
    output bcd_digit_t s,
    output logic       co,
    output logic       bad
);

    logic [4:0] w_t;

    assign w_t = {1'b0, a} + {1'b0, b} + {4'b0, ci};
    assign bad = (a > BCD_MAX) || (b > BCD_MAX);

    // Out-of-range digits still take the same correction, wrapping mod 16.
    always_comb begin
        s  = w_t[3:0];
        co = 1'b0;
        if (w_t > {1'b0, BCD_MAX}) begin
            s  = w_t[3:0] + BCD_ADJ;
            co = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_adder.sv
// Registered packed-BCD adder: ripple of digit slices, one output register stage.
module bcd_adder
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    bcd_adder_if.slave       bus
);

    localparam int unsigned W = 4 * DIGITS;

    logic [DIGITS:0]   w_c;
    logic [W-1:0]      w_sum;
    logic [DIGITS-1:0] w_bad;

    logic [W-1:0]      r_sum;
    logic              r_carry;
    logic              r_valid;
    logic              r_err;

    assign w_c[0] = bus.cin;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_add u_digit (
            .a   (bus.a[4*i +: 4]),
            .b   (bus.b[4*i +: 4]),
            .ci  (w_c[i]),
            .s   (w_sum[4*i +: 4]),
            .co  (w_c[i+1]),
            .bad (w_bad[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_sum   <= w_sum;
                r_carry <= w_c[DIGITS];
                r_err   <= |w_bad;
            end
        end
    end

    assign bus.sum       = r_sum;
    assign bus.carry     = r_carry;
    assign bus.out_valid = r_valid;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_bcd_adder.sv
// Directed scoreboard bench for bcd_adder at DIGITS=1 and DIGITS=2.
module tb_bcd_adder;

    typedef struct packed {
        logic [7:0] sum;
        logic       carry;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_mis = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t last1;

    always #5 clk = ~clk;

    bcd_adder_if #(.DIGITS(1)) if1 ();
    bcd_adder_if #(.DIGITS(2)) if2 ();

    bcd_adder #(.DIGITS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    bcd_adder #(.DIGITS(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    function automatic exp_t model(input int digits, input logic [7:0] a, input logic [7:0] b,
                                   input logic cin);
        exp_t r;
        int   c;
        int   t;
        int   da;
        int   db;
        r = '0;
        c = int'(cin);
        for (int i = 0; i < digits; i++) begin
            da = int'(a[4*i +: 4]);
            db = int'(b[4*i +: 4]);
            if (da > 9 || db > 9) r.err = 1'b1;
            t = da + db + c;
            if (t > 9) begin
                r.sum[4*i +: 4] = 4'((t + 6) % 16);
                c = 1;
            end else begin
                r.sum[4*i +: 4] = 4'(t);
                c = 0;
            end
        end
        r.carry = (c != 0);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op1(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic cin);
        exp_t e;
        @(negedge clk);
        if1.a = a; if1.b = b; if1.cin = cin; if1.in_valid = 1'b1;
        q1.push_back(model(1, {4'h0, a}, {4'h0, b}, cin));
        @(posedge clk); #1;
        if1.in_valid = 1'b0;
        check({tag, ".valid"}, 32'(if1.out_valid), 32'd1);
        if (q1.size() > 0) begin
            e = q1.pop_front();
            last1 = e;
            check({tag, ".sum"},   32'(if1.sum),   32'(e.sum[3:0]));
            check({tag, ".carry"}, 32'(if1.carry), 32'(e.carry));
            check({tag, ".err"},   32'(if1.err),   32'(e.err));
        end
    endtask

    task automatic op2(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic cin);
        exp_t e;
        @(negedge clk);
        if2.a = a; if2.b = b; if2.cin = cin; if2.in_valid = 1'b1;
        q2.push_back(model(2, a, b, cin));
        @(posedge clk); #1;
        if2.in_valid = 1'b0;
        check({tag, ".valid"}, 32'(if2.out_valid), 32'd1);
        if (q2.size() > 0) begin
            e = q2.pop_front();
            check({tag, ".sum"},   32'(if2.sum),   32'(e.sum));
            check({tag, ".carry"}, 32'(if2.carry), 32'(e.carry));
            check({tag, ".err"},   32'(if2.err),   32'(e.err));
        end
    endtask

    initial begin
        if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
        if2.in_valid = 1'b0; if2.a = '0; if2.b = '0; if2.cin = 1'b0;

        // Reset state
        #12;
        check("rst.valid1", 32'(if1.out_valid), 32'd0);
        check("rst.sum1",   32'(if1.sum),       32'd0);
        check("rst.valid2", 32'(if2.out_valid), 32'd0);
        check("rst.err2",   32'(if2.err),       32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single digit
        op1("zero",  4'd0,  4'd0, 1'b0);
        op1("6+9+1", 4'd6,  4'd9, 1'b1);
        op1("3+3",   4'd3,  4'd3, 1'b0);
        op1("4+5",   4'd4,  4'd5, 1'b0);
        op1("4+3+1", 4'd4,  4'd3, 1'b1);
        op1("3+5",   4'd3,  4'd5, 1'b0);
        op1("9+9+1", 4'd9,  4'd9, 1'b1);

        // Idle: out_valid drops, result holds
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("idle.valid", 32'(if1.out_valid), 32'd0);
            check("idle.sum",   32'(if1.sum),       32'(last1.sum[3:0]));
            check("idle.carry", 32'(if1.carry),     32'(last1.carry));
        end

        op1("12+0",  4'd12, 4'd0, 1'b0);
        op1("5+4",   4'd5,  4'd4, 1'b0);
        op1("0+15",  4'd0,  4'd15, 1'b1);

        // Two digits
        op2("99+01",   8'h99, 8'h01, 1'b0);
        op2("45+38+1", 8'h45, 8'h38, 1'b1);
        op2("A9+00",   8'hA9, 8'h00, 1'b0);

        // Asynchronous reset between edges, with operands pending
        @(negedge clk);
        if1.a = 4'd7; if1.b = 4'd8; if1.cin = 1'b1; if1.in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst.valid1", 32'(if1.out_valid), 32'd0);
        check("arst.sum1",   32'(if1.sum),       32'd0);
        check("arst.carry1", 32'(if1.carry),     32'd0);
        check("arst.err1",   32'(if1.err),       32'd0);
        check("arst.sum2",   32'(if2.sum),       32'd0);
        check("arst.carry2", 32'(if2.carry),     32'd0);
        @(negedge clk);
        if1.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("post.valid1", 32'(if1.out_valid), 32'd0);
        @(posedge clk); #1;
        check("post.valid1b", 32'(if1.out_valid), 32'd0);

        op1("after.2+2", 4'd2, 4'd2, 1'b0);

        check("q1.empty", 32'(q1.size()), 32'd0);
        check("q2.empty", 32'(q2.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
